i2c_master_ctrl: RTL and testbench
==================================

# i2c_master_ctrl

Command-driven, byte-level I2C master that sequences the open-drain `scl_drive`/`sda_drive` pair of the I2C bus interface. It accepts START, WRITE, READ and STOP commands through a valid/ready port and generates the bit-level SCL/SDA waveforms. It supports slave clock stretching and multi-master arbitration-loss detection. It returns exactly one response per command and sits between a register/host front-end and the bus pins.

## Interface
- `CLK_DIV`, 125: `clk` cycles per SCL quarter-period; minimum 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  3  command: 0 START, 1 WRITE, 2 READ, 3 STOP; 4–7 are illegal.
- `cmd_data`  in  8  byte for WRITE.
- `cmd_nack`  in  1  for READ: 1 sends NACK after the byte, 0 sends ACK.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_data`  out  8  byte received (READ) or byte as sampled on the bus (WRITE); 0 for other commands.
- `rsp_ack`  out  1  WRITE only: 1 when the slave pulled SDA low in the ACK bit.
- `rsp_arb_lost`  out  1  arbitration lost, or bus seen busy at START.
- `rsp_err`  out  1  illegal command.
- `busy`  out  1  1 while this master owns the bus (from a successful START until STOP or arbitration loss).
- `scl_drive`, `sda_drive`  out  1  0 drives the line low, 1 releases it.
- `scl_in`, `sda_in`  in  1  resolved bus values.

## Operation
- `scl_in` and `sda_in` each pass through a 2-flop synchronizer, giving `scl_s` and `sda_s`. All decisions use the synchronized values.
- Quarter counter: counts `CLK_DIV` cycles per phase.
  - In any phase with `scl_drive`=1 ("release-high" phase), the count starts only from the first cycle in which `scl_s`=1. This implements clock stretching with no timeout.
- States: IDLE, START(S0–S3), BIT(A,B,C,D), STOP(P0–P3), RESP.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, the command, data and nack are latched and `cmd_ready` drops the next cycle.
  - Illegal commands are: op 4–7, WRITE/READ/STOP while `busy`=0, and START while `busy`=1 is legal (repeated start). An illegal command goes directly to RESP with `rsp_err`=1 and causes no bus activity.
- START
  - S0: release SDA, SCL unchanged.
  - S1: release SCL (release-high phase). At the end of S1, `sda_s`=0 means arbitration is lost.
  - S2: SDA low.
  - S3: SCL low.
  - On success, `busy` is set.
- WRITE / READ: 9 bit cells, MSB first, then the ACK bit.
  - Cell A: SCL low; SDA is updated on entry.
  - Cell B: SCL low.
  - Cell C: SCL released (release-high phase). `sda_s` is sampled on the last cycle of C.
  - Cell D: SCL high.
  - SDA value driven in each cell:
    - WRITE data bits: the data bit.
    - WRITE ACK bit: released.
    - READ data bits: released.
    - READ ACK bit: `cmd_nack`.
  - `rsp_ack` = inverse of the sample taken in the ACK bit.
- Arbitration
  - Checked at every C sample point where `sda_drive`=1 was intended as data (WRITE data bits, READ ACK bit when NACK).
  - Lost when `sda_s`=0 at that point.
  - On loss: both drives are released on the next cycle, `busy` clears, and the block goes to RESP with `rsp_arb_lost`=1.
- STOP
  - P0: SDA low while SCL is low.
  - P1: release SCL (release-high phase).
  - P2: release SDA.
  - P3: idle quarter; `sda_s`=0 at its end means arbitration is lost.
  - `busy` clears at the end of P3.
- RESP
  - `rsp_valid`=1 for one cycle and `cmd_ready` returns high in the same cycle.
  - `rsp_*` fields hold their values until the next response.
- Reset (asynchronous, including mid-command)
  - `scl_drive`=1, `sda_drive`=1, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_ack`=0, `rsp_arb_lost`=0, `rsp_err`=0.
  - Synchronizers reset to 1.
  - No STOP is generated.

## Timing
- Release-high phase with no stretching: `scl_s` rises 2 cycles after `scl_drive` rises, so the phase lasts `CLK_DIV`+2 cycles.
- Command latency (accept cycle to `rsp_valid`, no stretching):
  - START: 4·`CLK_DIV`+2+1 cycles.
  - WRITE or READ: 9·(4·`CLK_DIV`+2)+1 cycles.
  - STOP: 4·`CLK_DIV`+2+1 cycles.
  - Illegal command: 2 cycles.
- Stretching adds cycles one-for-one while `scl_s`=0.
- Back-to-back commands: a new command can be accepted in the `rsp_valid` cycle.
- SDA never changes while this block holds SCL released, except in START S2 and STOP P2.

## Test plan
- Reset: assert `rst` mid-run → all outputs reach the reset values listed above immediately; `cmd_ready`=1 on the first cycle after release.
- `CLK_DIV`=4; START then WRITE 0xA5, slave ACKs → SDA levels at the C sample points are 1,0,1,0,0,1,0,1 then 0; `rsp_ack`=1, `rsp_data`=0xA5; WRITE latency is 163 cycles.
- READ with `cmd_nack`=1, slave returns 0x3C, then STOP → `rsp_data`=0x3C; SDA is released in the ACK cell; SDA rises while SCL is high; `busy`=0 after the STOP response.
- Slave holds SCL low for 50 cycles during bit 3 of a WRITE → that C phase is 50 cycles longer; `rsp_data` is correct; total latency is 213 cycles.
- Another master pulls SDA low at bit 2 of WRITE 0xFF → `rsp_arb_lost`=1; both drives read 1 the next cycle; `busy`=0; a following WRITE returns `rsp_err`=1 after 2 cycles.
- Illegal op 5 in IDLE → `rsp_err`=1 two cycles after acceptance; the bus is never driven.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Command-driven byte-level I2C master: START/WRITE/READ/STOP over a valid/ready port,
// open-drain SCL/SDA sequencing with clock stretching and arbitration-loss detection.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_ack,
  output logic       rsp_arb_lost,
  output logic       rsp_err,
  output logic       busy,
  output logic       scl_drive,
  output logic       sda_drive,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  localparam logic [2:0] OP_START = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_STOP  = 3'd3;

  typedef enum logic [4:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3,
    ST_BA, ST_BB, ST_BC, ST_BD,
    ST_P0, ST_P1, ST_P2, ST_P3,
    ST_ERR, ST_RESP
  } state_t;

  state_t state, state_n;

  logic          scl_m, scl_s, sda_m, sda_s;
  logic [CW-1:0] cnt;
  logic [1:0]    settle;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          ack_s;
  logic [2:0]    op_q;
  logic [7:0]    data_q;
  logic          nack_q;

  logic       scl_n, sda_n, busy_n, accept, illegal;
  logic       release_ph, cnt_en, phase_done, timed;
  logic       rsp_load, rsp_ack_n, rsp_arb_n, rsp_err_n;
  logic [7:0] rsp_data_n;

  function automatic logic sda_for_bit(input logic [2:0] op, input logic [7:0] data,
                                       input logic nack, input logic [3:0] idx);
    if (idx == 4'd8)
      return (op == OP_READ) ? nack : 1'b1;
    else
      return (op == OP_WRITE) ? data[3'(4'd7 - idx)] : 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
    end else begin
      scl_m <= scl_in;
      scl_s <= scl_m;
      sda_m <= sda_in;
      sda_s <= sda_m;
    end
  end

  assign cmd_ready = (state == ST_IDLE) || (state == ST_RESP);
  assign rsp_valid = (state == ST_RESP);
  assign illegal   = (cmd_op > OP_STOP) || ((cmd_op != OP_START) && !busy);

  // Release-high phases ignore the synchronizer latency and then wait for SCL to really be high.
  assign release_ph = (state == ST_S1) || (state == ST_BC) || (state == ST_P1);
  assign timed      = !((state == ST_IDLE) || (state == ST_RESP) || (state == ST_ERR));
  assign cnt_en     = (!scl_drive || scl_s) && (!release_ph || (settle == 2'd2));
  assign phase_done = cnt_en && (cnt == CNT_LAST);

  always_comb begin
    state_n    = state;
    scl_n      = scl_drive;
    sda_n      = sda_drive;
    busy_n     = busy;
    accept     = 1'b0;
    rsp_load   = 1'b0;
    rsp_data_n = 8'h00;
    rsp_ack_n  = 1'b0;
    rsp_arb_n  = 1'b0;
    rsp_err_n  = 1'b0;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (illegal) begin
            state_n = ST_ERR;
          end else begin
            case (cmd_op)
              OP_START: begin
                state_n = ST_S0;
                sda_n   = 1'b1;
              end
              OP_STOP: begin
                state_n = ST_P0;
                scl_n   = 1'b0;
                sda_n   = 1'b0;
              end
              default: begin
                state_n = ST_BA;
                scl_n   = 1'b0;
                sda_n   = sda_for_bit(cmd_op, cmd_data, cmd_nack, 4'd0);
              end
            endcase
          end
        end else if (state == ST_RESP) begin
          state_n = ST_IDLE;
        end
      end
      ST_S0: if (phase_done) begin
        state_n = ST_S1;
        scl_n   = 1'b1;
      end
      ST_S1: if (phase_done) begin
        if (!sda_s) begin
          state_n   = ST_RESP;
          sda_n     = 1'b1;
          busy_n    = 1'b0;
          rsp_load  = 1'b1;
          rsp_arb_n = 1'b1;
        end else begin
          state_n = ST_S2;
          sda_n   = 1'b0;
        end
      end
      ST_S2: if (phase_done) begin
        state_n = ST_S3;
        scl_n   = 1'b0;
      end
      ST_S3: if (phase_done) begin
        state_n  = ST_RESP;
        busy_n   = 1'b1;
        rsp_load = 1'b1;
      end
      ST_BA: if (phase_done) state_n = ST_BB;
      ST_BB: if (phase_done) begin
        state_n = ST_BC;
        scl_n   = 1'b1;
      end
      ST_BC: if (phase_done) begin
        // Only bits where we released SDA as data can reveal another master.
        if (sda_drive && !sda_s &&
            (((op_q == OP_WRITE) && (bit_idx != 4'd8)) ||
             ((op_q == OP_READ) && (bit_idx == 4'd8)))) begin
          state_n    = ST_RESP;
          scl_n      = 1'b1;
          sda_n      = 1'b1;
          busy_n     = 1'b0;
          rsp_load   = 1'b1;
          rsp_arb_n  = 1'b1;
          rsp_data_n = shreg;
        end else begin
          state_n = ST_BD;
        end
      end
      ST_BD: if (phase_done) begin
        scl_n = 1'b0;
        if (bit_idx == 4'd8) begin
          state_n    = ST_RESP;
          rsp_load   = 1'b1;
          rsp_data_n = shreg;
          rsp_ack_n  = (op_q == OP_WRITE) && !ack_s;
        end else begin
          state_n = ST_BA;
          sda_n   = sda_for_bit(op_q, data_q, nack_q, bit_idx + 4'd1);
        end
      end
      ST_P0: if (phase_done) begin
        state_n = ST_P1;
        scl_n   = 1'b1;
      end
      ST_P1: if (phase_done) begin
        state_n = ST_P2;
        sda_n   = 1'b1;
      end
      ST_P2: if (phase_done) state_n = ST_P3;
      ST_P3: if (phase_done) begin
        state_n   = ST_RESP;
        busy_n    = 1'b0;
        rsp_load  = 1'b1;
        rsp_arb_n = !sda_s;
      end
      ST_ERR: begin
        state_n   = ST_RESP;
        rsp_load  = 1'b1;
        rsp_err_n = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      scl_drive <= 1'b1;
      sda_drive <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      scl_drive <= scl_n;
      sda_drive <= sda_n;
      busy      <= busy_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      settle  <= 2'd0;
      bit_idx <= 4'd0;
      shreg   <= 8'h00;
      ack_s   <= 1'b0;
      op_q    <= 3'd0;
      data_q  <= 8'h00;
      nack_q  <= 1'b0;
    end else begin
      if (state_n != state) begin
        cnt    <= '0;
        settle <= 2'd0;
      end else begin
        if (timed && cnt_en) cnt <= cnt + 1'b1;
        if (settle != 2'd2) settle <= settle + 2'd1;
      end
      if (accept) begin
        op_q    <= cmd_op;
        data_q  <= cmd_data;
        nack_q  <= cmd_nack;
        bit_idx <= 4'd0;
        shreg   <= 8'h00;
        ack_s   <= 1'b0;
      end else begin
        if ((state == ST_BC) && phase_done) begin
          if (bit_idx == 4'd8) ack_s <= sda_s;
          else                 shreg <= {shreg[6:0], sda_s};
        end
        if ((state == ST_BD) && phase_done && (bit_idx != 4'd8))
          bit_idx <= bit_idx + 4'd1;
      end
    end
  end

  // Response fields are captured on entry to RESP and held until the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data     <= 8'h00;
      rsp_ack      <= 1'b0;
      rsp_arb_lost <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (rsp_load) begin
      rsp_data     <= rsp_data_n;
      rsp_ack      <= rsp_ack_n;
      rsp_arb_lost <= rsp_arb_n;
      rsp_err      <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl at CLK_DIV=4 with a simple slave, clock stretcher
// and competing-master model on the resolved open-drain bus.
module tb_i2c_master_ctrl;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ack, rsp_arb_lost, rsp_err, busy;
  logic       scl_drive, sda_drive;
  wire        scl_in, sda_in;

  logic slv_scl_low = 1'b0;
  logic slv_sda_low = 1'b0;
  logic oth_sda_low = 1'b0;

  int total = 0;
  int bad = 0;

  // slave_mode: 0 silent, 1 ACKs a write, 2 returns slave_byte on a read
  int         slave_mode = 0;
  logic [7:0] slave_byte = 8'h00;
  int         stretch_bit = -1;
  int         arb_bit = -1;

  int         lat;
  logic [8:0] samp;
  logic       ack_cell_drv, sda_rise_hi, drove;
  logic [7:0] r_data;
  logic       r_ack, r_arb, r_err, r_busy, r_scl, r_sda;

  assign scl_in = scl_drive & ~slv_scl_low;
  assign sda_in = sda_drive & ~slv_sda_low & ~oth_sda_low;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .rsp_arb_lost(rsp_arb_lost), .rsp_err(rsp_err), .busy(busy),
    .scl_drive(scl_drive), .sda_drive(sda_drive),
    .scl_in(scl_in), .sda_in(sda_in)
  );

  // Issues one command and runs the bus models cycle by cycle until its response.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, input logic nack);
    int n, fall_cnt, rise_cnt, hold_cnt;
    logic prev_scl, prev_sda, cur_scl, cur_sda, done;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_nack = nack;
    fall_cnt = 0; rise_cnt = 0; hold_cnt = 0; done = 1'b0;
    samp = '0; ack_cell_drv = 1'b0; sda_rise_hi = 1'b0; drove = 1'b0; lat = -1;
    slv_sda_low = (slave_mode == 2) && !slave_byte[7];
    prev_scl = scl_in; prev_sda = sda_in;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 1;
    while (!done && n <= 4000) begin
      cur_scl = scl_in; cur_sda = sda_in;
      if (!scl_drive || !sda_drive) drove = 1'b1;
      if (prev_scl && !cur_scl) begin
        fall_cnt++;
        if (fall_cnt == stretch_bit) slv_scl_low = 1'b1;
        if (fall_cnt == arb_bit) oth_sda_low = 1'b1;
      end
      if (!prev_scl && cur_scl) begin
        if (rise_cnt < 9) samp[8-rise_cnt] = cur_sda;
        if (rise_cnt == 8) ack_cell_drv = sda_drive;
        rise_cnt++;
      end
      if (prev_scl && cur_scl && !prev_sda && cur_sda) sda_rise_hi = 1'b1;
      prev_scl = cur_scl; prev_sda = cur_sda;
      if (slave_mode == 2 && fall_cnt < 8) slv_sda_low = !slave_byte[7-fall_cnt];
      else slv_sda_low = (slave_mode == 1) && (fall_cnt == 8);
      if (slv_scl_low && scl_drive) begin
        if (hold_cnt == 50) slv_scl_low = 1'b0;
        else hold_cnt++;
      end
      if (rsp_valid) begin
        lat = n; done = 1'b1;
        r_data = rsp_data; r_ack = rsp_ack; r_arb = rsp_arb_lost; r_err = rsp_err;
        r_busy = busy; r_scl = scl_drive; r_sda = sda_drive;
      end else begin
        @(posedge clk); #1; n++;
      end
    end
    if (!done) begin
      $display("[TB] FAIL cmd_timeout: op %0d got no response within %0d cycles", op, n);
      bad++; total++;
    end
    slv_scl_low = 1'b0; slv_sda_low = 1'b0; oth_sda_low = 1'b0;
    slave_mode = 0; stretch_bit = -1; arb_bit = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (scl_drive !== 1'b1) begin $display("[TB] FAIL rst_scl: got %b want 1", scl_drive); bad++; end
    total++;
    if (sda_drive !== 1'b1) begin $display("[TB] FAIL rst_sda: got %b want 1", sda_drive); bad++; end
    total++;
    if (cmd_ready !== 1'b1) begin $display("[TB] FAIL rst_ready: got %b want 1", cmd_ready); bad++; end
    total++;
    if (busy !== 1'b0) begin $display("[TB] FAIL rst_busy: got %b want 0", busy); bad++; end
    total++;
    if (rsp_valid !== 1'b0) begin $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid); bad++; end
    total++;
    if ({rsp_data, rsp_ack, rsp_arb_lost, rsp_err} !== 11'h000) begin
      $display("[TB] FAIL rst_rsp_fields: got %h want 000", {rsp_data, rsp_ack, rsp_arb_lost, rsp_err}); bad++;
    end
    total++;
    rst = 1'b0;
    @(posedge clk); #1;
    if (cmd_ready !== 1'b1) begin $display("[TB] FAIL rst_ready_after: got %b want 1", cmd_ready); bad++; end
    total++;
  endtask

  task automatic test_write_ack();
    do_cmd(3'd0, 8'h00, 1'b0);
    if (lat != 19) begin $display("[TB] FAIL start_latency: got %0d want 19", lat); bad++; end
    total++;
    if (r_busy !== 1'b1 || r_arb !== 1'b0) begin
      $display("[TB] FAIL start_status: got busy=%b arb=%b want busy=1 arb=0", r_busy, r_arb); bad++;
    end
    total++;
    slave_mode = 1;
    do_cmd(3'd1, 8'hA5, 1'b0);
    if (samp !== 9'b101001010) begin $display("[TB] FAIL write_samples: got %b want 101001010", samp); bad++; end
    total++;
    if (r_ack !== 1'b1) begin $display("[TB] FAIL write_ack: got %b want 1", r_ack); bad++; end
    total++;
    if (r_data !== 8'hA5) begin $display("[TB] FAIL write_data: got %h want a5", r_data); bad++; end
    total++;
    if (lat != 163) begin $display("[TB] FAIL write_latency: got %0d want 163", lat); bad++; end
    total++;
  endtask

  task automatic test_read_stop();
    slave_mode = 2; slave_byte = 8'h3C;
    do_cmd(3'd2, 8'h00, 1'b1);
    if (r_data !== 8'h3C) begin $display("[TB] FAIL read_data: got %h want 3c", r_data); bad++; end
    total++;
    if (samp !== 9'b001111001) begin $display("[TB] FAIL read_samples: got %b want 001111001", samp); bad++; end
    total++;
    if (ack_cell_drv !== 1'b1 || r_ack !== 1'b0) begin
      $display("[TB] FAIL read_nack_cell: got sda=%b ack=%b want sda=1 ack=0", ack_cell_drv, r_ack); bad++;
    end
    total++;
    if (lat != 163) begin $display("[TB] FAIL read_latency: got %0d want 163", lat); bad++; end
    total++;
    do_cmd(3'd3, 8'h00, 1'b0);
    if (sda_rise_hi !== 1'b1) begin $display("[TB] FAIL stop_condition: got %b want 1", sda_rise_hi); bad++; end
    total++;
    if (r_busy !== 1'b0 || r_arb !== 1'b0) begin
      $display("[TB] FAIL stop_status: got busy=%b arb=%b want busy=0 arb=0", r_busy, r_arb); bad++;
    end
    total++;
    if (lat != 19) begin $display("[TB] FAIL stop_latency: got %0d want 19", lat); bad++; end
    total++;
  endtask

  task automatic test_stretch();
    do_cmd(3'd0, 8'h00, 1'b0);
    slave_mode = 1; stretch_bit = 3;
    do_cmd(3'd1, 8'h5A, 1'b0);
    if (lat != 213) begin $display("[TB] FAIL stretch_latency: got %0d want 213", lat); bad++; end
    total++;
    if (r_data !== 8'h5A || r_ack !== 1'b1) begin
      $display("[TB] FAIL stretch_rsp: got data=%h ack=%b want data=5a ack=1", r_data, r_ack); bad++;
    end
    total++;
    do_cmd(3'd3, 8'h00, 1'b0);
    if (r_busy !== 1'b0) begin $display("[TB] FAIL stretch_stop_busy: got %b want 0", r_busy); bad++; end
    total++;
  endtask

  task automatic test_arb_lost();
    do_cmd(3'd0, 8'h00, 1'b0);
    arb_bit = 2;
    do_cmd(3'd1, 8'hFF, 1'b0);
    if (r_arb !== 1'b1) begin $display("[TB] FAIL arb_flag: got %b want 1", r_arb); bad++; end
    total++;
    if (lat != 51) begin $display("[TB] FAIL arb_latency: got %0d want 51", lat); bad++; end
    total++;
    if (r_busy !== 1'b0 || r_scl !== 1'b1 || r_sda !== 1'b1) begin
      $display("[TB] FAIL arb_release: got busy=%b scl=%b sda=%b want 0 1 1", r_busy, r_scl, r_sda); bad++;
    end
    total++;
    do_cmd(3'd1, 8'h00, 1'b0);
    if (r_err !== 1'b1 || r_arb !== 1'b0) begin
      $display("[TB] FAIL arb_then_write_err: got err=%b arb=%b want err=1 arb=0", r_err, r_arb); bad++;
    end
    total++;
    if (lat != 2) begin $display("[TB] FAIL arb_then_write_latency: got %0d want 2", lat); bad++; end
    total++;
    if (drove !== 1'b0) begin $display("[TB] FAIL arb_then_bus_idle: got drove=%b want 0", drove); bad++; end
    total++;
  endtask

  task automatic test_illegal();
    do_cmd(3'd5, 8'hFF, 1'b0);
    if (r_err !== 1'b1) begin $display("[TB] FAIL illegal_err: got %b want 1", r_err); bad++; end
    total++;
    if (lat != 2) begin $display("[TB] FAIL illegal_latency: got %0d want 2", lat); bad++; end
    total++;
    if (drove !== 1'b0) begin $display("[TB] FAIL illegal_bus: got drove=%b want 0", drove); bad++; end
    total++;
    if (r_data !== 8'h00 || r_ack !== 1'b0) begin
      $display("[TB] FAIL illegal_fields: got data=%h ack=%b want 00 0", r_data, r_ack); bad++;
    end
    total++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    if (sda_drive !== 1'b1 || scl_drive !== 1'b1) begin
      $display("[TB] FAIL midrst_drives: got scl=%b sda=%b want 1 1", scl_drive, sda_drive); bad++;
    end
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      $display("[TB] FAIL midrst_ctrl: got ready=%b busy=%b valid=%b want 1 0 0", cmd_ready, busy, rsp_valid); bad++;
    end
    total++;
    if (rsp_err !== 1'b0) begin $display("[TB] FAIL midrst_err: got %b want 0", rsp_err); bad++; end
    total++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    if (cmd_ready !== 1'b1 || scl_drive !== 1'b1) begin
      $display("[TB] FAIL midrst_after: got ready=%b scl=%b want 1 1", cmd_ready, scl_drive); bad++;
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_stop();
    test_stretch();
    test_arb_lost();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
